mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/wait_counter.sv | 25 ++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the SRAM arbiter
package mem_arb_pkg;

    localparam int WAIT_CYCLES_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/wait_counter.sv
// rtl/wait_counter.sv - 4-bit loadable down-counter with zero flag
module wait_counter (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [3:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != 4'd0)) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin CPU/loader arbiter for an async SRAM
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic        ldr_req,
    input  logic        ldr_we,
    input  logic [15:0] ldr_addr,
    input  logic [15:0] ldr_wdata,
    output logic [15:0] ldr_rdata,
    output logic        ldr_ready,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        OE,
    output logic        WE,
    output logic        busy,
    output logic        grant_ldr
);

    // Counter runs WAIT_CYCLES-1 .. 0, so ACCESS lasts exactly WAIT_CYCLES cycles
    localparam logic [3:0] LP_LOAD = 4'(WAIT_CYCLES - 1);

    arb_state_t  r_state;
    logic        r_we;
    logic        r_owner_ldr;
    logic        r_ldr_next;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_cpu_rdata;
    logic [15:0] r_ldr_rdata;

    logic        w_any_req;
    logic        w_pick_ldr;
    logic        w_in_access;
    logic        w_in_done;
    logic        w_cnt_load;
    logic        w_cnt_dec;
    logic        w_cnt_zero;

    assign w_any_req   = cpu_req | ldr_req;
    assign w_pick_ldr  = ldr_req & (~cpu_req | r_ldr_next);
    assign w_in_access = (r_state == ST_ACCESS);
    assign w_in_done   = (r_state == ST_DONE);
    assign w_cnt_load  = (r_state == ST_SETUP);
    assign w_cnt_dec   = w_in_access & ~w_cnt_zero;

    wait_counter u_wait_counter (
        .i_clk      (Clk),
        .i_rst_n    (Reset),
        .i_load     (w_cnt_load),
        .i_load_val (LP_LOAD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_owner_ldr <= 1'b0;
            r_ldr_next  <= 1'b1;
            r_addr      <= 16'h0000;
            r_wdata     <= 16'h0000;
            r_cpu_rdata <= 16'h0000;
            r_ldr_rdata <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state     <= ST_SETUP;
                        r_owner_ldr <= w_pick_ldr;
                        r_ldr_next  <= ~w_pick_ldr;
                        r_we        <= w_pick_ldr ? ldr_we    : cpu_we;
                        r_addr      <= w_pick_ldr ? ldr_addr  : cpu_addr;
                        r_wdata     <= w_pick_ldr ? ldr_wdata : cpu_wdata;
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (w_cnt_zero) begin
                        r_state <= ST_DONE;
                        // Capture while OE is still low on the final access edge
                        if (!r_we) begin
                            if (r_owner_ldr) begin
                                r_ldr_rdata <= mem_rdata;
                            end else begin
                                r_cpu_rdata <= mem_rdata;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobes decode from state so an async reset releases them at once
    assign OE        = ~(w_in_access & ~r_we);
    assign WE        = ~(w_in_access & r_we);
    assign busy      = (r_state != ST_IDLE);
    assign cpu_ready = w_in_done & ~r_owner_ldr;
    assign ldr_ready = w_in_done & r_owner_ldr;
    assign grant_ldr = r_owner_ldr;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign cpu_rdata = r_cpu_rdata;
    assign ldr_rdata = r_ldr_rdata;

endmodule
